// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: on a cache miss, picks a victim way, fetches the line from memory,
// writes its beats into the data array and then writes the tag.
module line_fill_ctrl #(
  parameter int N_WAYS = 2,
  parameter int TAG_BITS = 22,
  parameter int N_POW = 4,
  parameter int SET_BITS = 4,
  parameter int BEATS = 4,
  parameter int DATA_W = 32,
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         miss_req,
  input  logic [TAG_BITS-1:0]          miss_tag,
  input  logic [SET_BITS-1:0]          miss_set,
  input  logic [N_WAYS-1:0]            line_empty,
  output logic                         miss_ack,
  output logic                         busy,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [TAG_BITS+SET_BITS-1:0] mem_req_addr,
  input  logic                         mem_rdata_valid,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         data_we,
  output logic [N_POW-1:0]             data_way,
  output logic [SET_BITS-1:0]          data_set,
  output logic [BW-1:0]                data_beat,
  output logic [DATA_W-1:0]            data_wdata,
  output logic                         tag_we,
  output logic [N_POW-1:0]             tag_way,
  output logic [SET_BITS-1:0]          tag_set,
  output logic [TAG_BITS-1:0]          tag_wdata,
  output logic                         fill_done
);
  typedef enum logic [1:0] {IDLE, REQ, FILL, TAGWR} state_t;
  state_t               state;
  logic [BW-1:0]        beat;
  logic [TAG_BITS-1:0]  tag_q;
  logic [SET_BITS-1:0]  set_q;
  logic [N_POW-1:0]     way_q;
  logic [N_POW-1:0]     victim;
  logic [N_POW-1:0]     rr_ptr [2**SET_BITS];
  // lowest empty way wins; a full set falls back to its round-robin pointer
  always_comb begin
    victim = rr_ptr[miss_set];
    for (int i = N_WAYS - 1; i >= 0; i--)
      if (line_empty[i]) victim = N_POW'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
      tag_q <= '0;
      set_q <= '0;
      way_q <= '0;
      for (int s = 0; s < 2**SET_BITS; s++) rr_ptr[s] <= '0;
    end else begin
      case (state)
        IDLE: if (miss_req) begin
          tag_q <= miss_tag;
          set_q <= miss_set;
          way_q <= victim;
          state <= REQ;
        end
        REQ: if (mem_req_ready) begin
          beat  <= '0;
          state <= FILL;
        end
        FILL: if (mem_rdata_valid) begin
          beat <= beat + 1'b1;
          if (beat == BW'(BEATS - 1)) state <= TAGWR;
        end
        TAGWR: begin
          rr_ptr[set_q] <= (rr_ptr[set_q] == N_POW'(N_WAYS - 1)) ? '0 : rr_ptr[set_q] + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign miss_ack      = (state == IDLE) & miss_req;
  assign busy          = state != IDLE;
  assign mem_req_valid = state == REQ;
  assign mem_req_addr  = {tag_q, set_q};
  assign data_we       = (state == FILL) & mem_rdata_valid;
  assign data_way      = way_q;
  assign data_set      = set_q;
  assign data_beat     = beat;
  assign data_wdata    = mem_rdata;
  assign tag_we        = state == TAGWR;
  assign fill_done     = state == TAGWR;
  assign tag_way       = way_q;
  assign tag_set       = set_q;
  assign tag_wdata     = tag_q;
endmodule

// File: tb/tb_line_fill_ctrl.sv
// tb_line_fill_ctrl: random miss/memory traffic checked by a fill-level reference model and scoreboard.
module tb_line_fill_ctrl;
  localparam int TB = 22, SB = 4, NW = 2, NP = 4, NB = 4, DW = 32;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic miss_req = 0, mem_req_ready = 0, mem_rdata_valid = 0;
  logic [TB-1:0] miss_tag = '0;
  logic [SB-1:0] miss_set = '0;
  logic [NW-1:0] line_empty = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic miss_ack, busy, mem_req_valid, data_we, tag_we, fill_done;
  logic [TB+SB-1:0] mem_req_addr;
  logic [NP-1:0] data_way, tag_way;
  logic [SB-1:0] data_set, tag_set;
  logic [1:0] data_beat;
  logic [DW-1:0] data_wdata;
  logic [TB-1:0] tag_wdata;
  line_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_tag(miss_tag), .miss_set(miss_set),
    .line_empty(line_empty), .miss_ack(miss_ack), .busy(busy), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata(mem_rdata), .data_we(data_we), .data_way(data_way), .data_set(data_set),
    .data_beat(data_beat), .data_wdata(data_wdata), .tag_we(tag_we), .tag_way(tag_way),
    .tag_set(tag_set), .tag_wdata(tag_wdata), .fill_done(fill_done));
  logic b_miss_req = 0;
  logic [TB-1:0] b_miss_tag = '0;
  logic [SB-1:0] b_miss_set = '0;
  logic [2:0] b_line_empty = '0;
  logic [DW-1:0] b_rdata = '0;
  logic b_miss_ack, b_busy, b_mem_req_valid, b_data_we, b_tag_we, b_fill_done;
  logic [TB+SB-1:0] b_mem_req_addr;
  logic [NP-1:0] b_data_way, b_tag_way;
  logic [SB-1:0] b_data_set, b_tag_set;
  logic [0:0] b_data_beat;
  logic [DW-1:0] b_data_wdata;
  logic [TB-1:0] b_tag_wdata;
  line_fill_ctrl #(.N_WAYS(3), .BEATS(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .miss_req(b_miss_req), .miss_tag(b_miss_tag), .miss_set(b_miss_set),
    .line_empty(b_line_empty), .miss_ack(b_miss_ack), .busy(b_busy), .mem_req_valid(b_mem_req_valid),
    .mem_req_ready(1'b1), .mem_req_addr(b_mem_req_addr), .mem_rdata_valid(1'b1),
    .mem_rdata(b_rdata), .data_we(b_data_we), .data_way(b_data_way), .data_set(b_data_set),
    .data_beat(b_data_beat), .data_wdata(b_data_wdata), .tag_we(b_tag_we), .tag_way(b_tag_way),
    .tag_set(b_tag_set), .tag_wdata(b_tag_wdata), .fill_done(b_fill_done));
  typedef struct {
    logic [TB+SB-1:0] addr;
    int               way;
    logic [SB-1:0]    set;
    logic [TB-1:0]    tag;
  } fill_t;
  fill_t exp_q[$];
  int rr[16];
  int n_chk = 0, n_fail = 0;
  bit fast = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [NW-1:0] e, input int p);
    for (int i = 0; i < NW; i++) if (e[i]) return i;
    return p;
  endfunction
  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  // presents a miss and leaves miss_req high; caller either issues the next miss or drops it
  task automatic issue(input logic [TB-1:0] t, input logic [SB-1:0] s, input logic [NW-1:0] e);
    int k = 0;
    miss_req = 1; miss_tag = t; miss_set = s; line_empty = e;
    do begin @(negedge clk); k++; end while (!miss_ack && k < 400);
    check("ack_seen", miss_ack, 1);
    exp_q.push_back('{addr: {t, s}, way: pick(e, rr[s]), set: s, tag: t});
    rr[s] = (rr[s] + 1) % NW;
    @(posedge clk); #1;
  endtask
  task automatic drop();
    miss_req = 0;
    line_empty = NW'($urandom);
  endtask
  task automatic wait_idle();
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin @(posedge clk); #1; k++; end
    check("fill_completed", exp_q.size(), 0);
  endtask
  task automatic check_reset_outputs(input string name);
    check({name, "_strobes"}, {miss_ack, busy, mem_req_valid, data_we, tag_we, fill_done}, 0);
    check({name, "_latched"}, {mem_req_addr, tag_way, data_beat}, 0);
  endtask
  initial forever begin
    @(posedge clk); #1;
    mem_req_ready   = fast ? 1'b1 : ($urandom_range(0, 3) == 0);
    mem_rdata_valid = fast ? 1'b1 : 1'($urandom_range(0, 1));
    mem_rdata       = $urandom;
  end
  initial begin
    int beat = 0, ack_cyc = 0, cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin beat = 0; continue; end
      if (miss_ack) begin check("ack_only_idle", busy, 0); ack_cyc = cyc; end
      if (data_we || tag_we) check("we_exclusive", data_we & tag_we, 0);
      if (fill_done) check("done_with_tag", tag_we, 1);
      if (exp_q.size() == 0) begin
        if (mem_req_valid || data_we || tag_we) check("stray_activity", {mem_req_valid, data_we, tag_we}, 0);
      end else begin
        if (mem_req_valid) check("req_addr", mem_req_addr, exp_q[0].addr);
        if (data_we) begin
          check("data_needs_valid", mem_rdata_valid, 1);
          check("data_beat", data_beat, beat);
          check("data_way", data_way, exp_q[0].way);
          check("data_set", data_set, exp_q[0].set);
          check("data_wdata", data_wdata, mem_rdata);
          beat++;
        end
        if (tag_we) begin
          check("beats_before_tag", beat, NB);
          check("tag_way", tag_way, exp_q[0].way);
          check("tag_set", tag_set, exp_q[0].set);
          check("tag_wdata", tag_wdata, exp_q[0].tag);
          check("fill_done", fill_done, 1);
          if (fast) check("fill_latency", cyc - ack_cyc, 2 + NB);
          void'(exp_q.pop_front());
          beat = 0;
        end
      end
    end
  end
  initial begin
    int k, rr3;
    logic [TB-1:0] t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1;
    gap(2);
    issue(22'h15A, 4'd3, 2'b10);
    drop();
    wait_idle();
    issue(22'h00101, 4'd5, 2'b00);
    issue(22'h00202, 4'd6, 2'b00);
    issue(22'h00303, 4'd5, 2'b00);
    issue(22'h00404, 4'd5, 2'b00);
    drop();
    wait_idle();
    fast = 1;
    gap(2);
    issue(22'h2ABCD, 4'd7, 2'b00);
    drop();
    wait_idle();
    issue(22'h1F00F, 4'd7, 2'b01);
    drop();
    wait_idle();
    fast = 0;
    gap(2);
    for (int i = 0; i < 30; i++) begin
      issue(TB'($urandom), SB'($urandom_range(0, 3)), NW'($urandom));
      if ($urandom_range(0, 1) == 1) begin drop(); gap($urandom_range(0, 3)); end
    end
    drop();
    wait_idle();
    issue(22'h3C3C3, 4'd5, 2'b00);
    drop();
    k = 0;
    while (k < 2) begin @(negedge clk); if (data_we) k++; end
    @(posedge clk); #1 rst_n = 0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    foreach (rr[s]) rr[s] = 0;
    gap(2);
    @(negedge clk);
    check("no_tag_in_reset", tag_we, 0);
    @(posedge clk); #1 rst_n = 1;
    gap(1);
    issue(22'h0BEEF, 4'd5, 2'b00);
    drop();
    wait_idle();
    rr3 = 0;
    for (int f = 0; f < 4; f++) begin
      t = TB'($urandom);
      b_rdata = $urandom;
      b_miss_req = 1; b_miss_tag = t; b_miss_set = 4'd2; b_line_empty = '0;
      k = 0;
      do begin @(negedge clk); k++; end while (!b_miss_ack && k < 50);
      check("b_ack_seen", b_miss_ack, 1);
      @(posedge clk); #1 b_miss_req = 0;
      k = 0;
      do begin
        @(negedge clk); k++;
        if (b_miss_ack) check("b_ack_only_idle", b_busy, 0);
        if (b_mem_req_valid) check("b_req_addr", b_mem_req_addr, {t, 4'd2});
        if (b_data_we) begin
          check("b_data_way", b_data_way, rr3);
          check("b_data_loc", {b_data_set, b_data_beat}, {4'd2, 1'b0});
          check("b_data_wdata", b_data_wdata, b_rdata);
        end
      end while (!b_tag_we && k < 50);
      check("b_latency", k, 3);
      check("b_victim", b_tag_way, rr3);
      check("b_tag", {b_tag_set, b_tag_wdata}, {4'd2, t});
      check("b_fill_done", b_fill_done, 1);
      rr3 = (rr3 + 1) % 3;
      gap(1);
    end
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
